// File: rtl/card_pkg.sv
// Shared card/segment definitions for the card <-> 7-segment encoder and decoder.
// Segment bit order is a..g on bits 6..0, 1 = lit.
package card_pkg;

  localparam logic [3:0] CARD_BLANK = 4'd0;
  localparam logic [3:0] CARD_ACE   = 4'd1;
  localparam logic [3:0] CARD_TWO   = 4'd2;
  localparam logic [3:0] CARD_THREE = 4'd3;
  localparam logic [3:0] CARD_FOUR  = 4'd4;
  localparam logic [3:0] CARD_FIVE  = 4'd5;
  localparam logic [3:0] CARD_SIX   = 4'd6;
  localparam logic [3:0] CARD_SEVEN = 4'd7;
  localparam logic [3:0] CARD_EIGHT = 4'd8;
  localparam logic [3:0] CARD_NINE  = 4'd9;
  localparam logic [3:0] CARD_TEN   = 4'd10;
  localparam logic [3:0] CARD_JACK  = 4'd11;
  localparam logic [3:0] CARD_QUEEN = 4'd12;
  localparam logic [3:0] CARD_KING  = 4'd13;
  localparam logic [3:0] CARD_ERR   = 4'd15;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_ACE   = 7'b1110111;
  localparam logic [6:0] SEG_TWO   = 7'b1101101;
  localparam logic [6:0] SEG_THREE = 7'b1111001;
  localparam logic [6:0] SEG_FOUR  = 7'b0110011;
  localparam logic [6:0] SEG_FIVE  = 7'b1011011;
  localparam logic [6:0] SEG_SIX   = 7'b1011111;
  localparam logic [6:0] SEG_SEVEN = 7'b1110000;
  localparam logic [6:0] SEG_EIGHT = 7'b1111111;
  localparam logic [6:0] SEG_NINE  = 7'b1111011;
  localparam logic [6:0] SEG_TEN   = 7'b1111110;
  localparam logic [6:0] SEG_JACK  = 7'b0111100;
  localparam logic [6:0] SEG_QUEEN = 7'b1110011;
  localparam logic [6:0] SEG_KING  = 7'b0110111;

  typedef enum logic [0:0] {
    TRACK = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic logic [3:0] seg_to_card(input logic [6:0] seg);
    logic [3:0] code;
    case (seg)
      SEG_BLANK: code = CARD_BLANK;
      SEG_ACE:   code = CARD_ACE;
      SEG_TWO:   code = CARD_TWO;
      SEG_THREE: code = CARD_THREE;
      SEG_FOUR:  code = CARD_FOUR;
      SEG_FIVE:  code = CARD_FIVE;
      SEG_SIX:   code = CARD_SIX;
      SEG_SEVEN: code = CARD_SEVEN;
      SEG_EIGHT: code = CARD_EIGHT;
      SEG_NINE:  code = CARD_NINE;
      SEG_TEN:   code = CARD_TEN;
      SEG_JACK:  code = CARD_JACK;
      SEG_QUEEN: code = CARD_QUEEN;
      SEG_KING:  code = CARD_KING;
      default:   code = CARD_ERR;
    endcase
    return code;
  endfunction

  // Baccarat points: face value for ace..nine, zero for everything else.
  function automatic logic [3:0] card_points(input logic [3:0] code);
    logic [3:0] pts;
    if ((code >= CARD_ACE) && (code <= CARD_NINE)) begin
      pts = code;
    end else begin
      pts = 4'd0;
    end
    return pts;
  endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// Input register plus saturating run-length counter; stable marks a pattern held
// for STABLE_CYCLES samples. Define SEG_ACTIVE_LOW_EN for raw active-low HEX drive.
module seg_stable_filter #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [6:0] seg_in,
  output logic [6:0] seg_q,
  output logic       stable
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [6:0]    seg_s;
  logic [6:0]    seg_q_r;
  logic [CW-1:0] cnt_r;

`ifdef SEG_ACTIVE_LOW_EN
  assign seg_s = ~seg_in;
`else
  assign seg_s = seg_in;
`endif

  // Sample the pattern and count how long it has been held.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      seg_q_r <= 7'b0000000;
      cnt_r   <= '0;
    end else begin
      seg_q_r <= seg_s;
      if (seg_s == seg_q_r) begin
        if (cnt_r != CNT_MAX) begin
          cnt_r <= cnt_r + CNT_ONE;
        end else begin
          cnt_r <= cnt_r;
        end
      end else begin
        cnt_r <= CNT_ONE;
      end
    end
  end

  assign seg_q  = seg_q_r;
  assign stable = (cnt_r == CNT_MAX);

endmodule

// File: rtl/seg7_card_decode.sv
// Decodes a debounced 7-segment pattern back to card code and baccarat points,
// reporting each newly stable pattern once over valid/ready. Option: SEG_ACTIVE_LOW_EN.
module seg7_card_decode #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [6:0] seg_in,
  input  logic       card_ready,
  output logic       card_valid,
  output logic [3:0] card_code,
  output logic [3:0] card_value,
  output logic       card_err
);

  import card_pkg::*;

  logic [6:0] seg_q_s;
  logic       stable_s;
  logic [3:0] dec_code_s;
  logic [6:0] last_rep_r;
  state_t     state_r;

  seg_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .slow_clock(slow_clock),
    .resetb    (resetb),
    .seg_in    (seg_in),
    .seg_q     (seg_q_s),
    .stable    (stable_s)
  );

  assign dec_code_s = seg_to_card(seg_q_s);

  // Report FSM; last_rep starts blank so the idle display never produces a result.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_r    <= TRACK;
      last_rep_r <= SEG_BLANK;
      card_valid <= 1'b0;
      card_err   <= 1'b0;
      card_code  <= CARD_BLANK;
      card_value <= 4'd0;
    end else begin
      case (state_r)
        TRACK: begin
          if (stable_s && (seg_q_s != last_rep_r)) begin
            card_code  <= dec_code_s;
            card_value <= card_points(dec_code_s);
            card_err   <= (dec_code_s == CARD_ERR);
            card_valid <= 1'b1;
            last_rep_r <= seg_q_s;
            state_r    <= HOLD;
          end else begin
            state_r <= TRACK;
          end
        end
        HOLD: begin
          if (card_valid && card_ready) begin
            card_valid <= 1'b0;
            card_err   <= 1'b0;
            state_r    <= TRACK;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          card_valid <= 1'b0;
          card_err   <= 1'b0;
          state_r    <= TRACK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_card_decode.sv
// Self-checking bench for seg7_card_decode: directed scenarios plus randomized
// traffic compared against a sample-history reference model.
module tb_seg7_card_decode;

  localparam int S = 4;

  logic       slow_clock;
  logic       resetb;
  logic [6:0] seg_in;
  logic       card_ready;
  logic       card_valid;
  logic [3:0] card_code;
  logic [3:0] card_value;
  logic       card_err;

  int n_checks;
  int n_errors;

  // reference model state
  logic [6:0] hist[$];
  logic [6:0] m_last;
  logic       m_valid;
  logic [3:0] m_code;
  logic [3:0] m_value;
  logic       m_err;

  logic [6:0] tbl [0:13] = '{7'b0000000, 7'b1110111, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1111110, 7'b0111100,
                             7'b1110011, 7'b0110111};

  seg7_card_decode #(.STABLE_CYCLES(S)) dut (
    .slow_clock(slow_clock),
    .resetb    (resetb),
    .seg_in    (seg_in),
    .card_ready(card_ready),
    .card_valid(card_valid),
    .card_code (card_code),
    .card_value(card_value),
    .card_err  (card_err)
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  function automatic int ref_code(input logic [6:0] p);
    for (int i = 0; i < 14; i++) begin
      if (tbl[i] == p) return i;
    end
    return 15;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_last  = 7'b0000000;
    m_valid = 1'b0;
    m_code  = 4'd0;
    m_value = 4'd0;
    m_err   = 1'b0;
  endtask

  task automatic model_edge(input logic [6:0] s, input logic rdy);
    bit stable;
    int c;
    stable = (hist.size() >= S);
    if (stable) begin
      for (int i = 0; i < S; i++) begin
        if (hist[hist.size() - 1 - i] != hist[hist.size() - 1]) stable = 0;
      end
    end
    if (m_valid) begin
      if (rdy) begin
        m_valid = 1'b0;
        m_err   = 1'b0;
      end
    end else if (stable && (hist[hist.size() - 1] != m_last)) begin
      m_last  = hist[hist.size() - 1];
      c       = ref_code(m_last);
      m_code  = 4'(c);
      m_value = (c >= 1 && c <= 9) ? 4'(c) : 4'd0;
      m_err   = (c == 15);
      m_valid = 1'b1;
    end
    hist.push_back(s);
    if (hist.size() > S) void'(hist.pop_front());
  endtask

  // one clock: drive inputs, take the edge, settle 1 time unit past it
  task automatic step(input logic [6:0] s, input logic rdy);
    seg_in     = s;
    card_ready = rdy;
    @(posedge slow_clock);
    model_edge(s, rdy);
    #1;
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    seg_in = 7'b0000000;
    card_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge slow_clock);
    #1;
    n_checks++; if (card_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", card_valid); end
    n_checks++; if (card_code !== 4'd0) begin n_errors++; $display("FAIL reset_code got %0d want 0", card_code); end
    n_checks++; if (card_value !== 4'd0) begin n_errors++; $display("FAIL reset_value got %0d want 0", card_value); end
    n_checks++; if (card_err !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b want 0", card_err); end
    resetb = 1'b1;
  endtask

  task automatic test_blank_idle();
    int nv;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      step(7'b0000000, 1'b1);
      if (card_valid) nv++;
    end
    n_checks++; if (nv !== 0) begin n_errors++; $display("FAIL blank_idle valid_cycles got %0d want 0", nv); end
  endtask

  task automatic test_ace();
    int nv;
    int first;
    logic [3:0] c, v;
    logic e;
    nv = 0; first = -1; c = 4'd0; v = 4'd0; e = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step(7'b1110111, 1'b1);
      if (card_valid) begin
        nv++;
        if (first < 0) first = i;
        c = card_code; v = card_value; e = card_err;
      end
    end
    n_checks++; if (nv !== 1) begin n_errors++; $display("FAIL ace_count got %0d want 1", nv); end
    n_checks++; if (first !== S + 1) begin n_errors++; $display("FAIL ace_latency got %0d want %0d", first, S + 1); end
    n_checks++; if (c !== 4'd1) begin n_errors++; $display("FAIL ace_code got %0d want 1", c); end
    n_checks++; if (v !== 4'd1) begin n_errors++; $display("FAIL ace_value got %0d want 1", v); end
    n_checks++; if (e !== 1'b0) begin n_errors++; $display("FAIL ace_err got %b want 0", e); end
  endtask

  task automatic test_king_backpressure();
    int drops;
    drops = 0;
    for (int i = 1; i <= 14; i++) begin
      step(7'b0110111, 1'b0);
      if (i > S && (card_valid !== 1'b1 || card_code !== 4'd13 || card_value !== 4'd0)) drops++;
    end
    n_checks++; if (drops !== 0) begin n_errors++; $display("FAIL king_hold bad_cycles got %0d want 0", drops); end
    n_checks++; if (card_code !== 4'd13) begin n_errors++; $display("FAIL king_code got %0d want 13", card_code); end
    step(7'b0110111, 1'b1);
    n_checks++; if (card_valid !== 1'b0) begin n_errors++; $display("FAIL king_accept valid got %b want 0", card_valid); end
    drops = 0;
    for (int i = 0; i < 6; i++) begin
      step(7'b0110111, 1'b1);
      if (card_valid) drops++;
    end
    n_checks++; if (drops !== 0) begin n_errors++; $display("FAIL king_repeat valid_cycles got %0d want 0", drops); end
  endtask

  task automatic test_glitch();
    int nv;
    logic [3:0] c, v;
    nv = 0; c = 4'd0; v = 4'd0;
    for (int i = 0; i < 30; i++) begin
      step(((i / 2) % 2 == 0) ? 7'b1111111 : 7'b1111011, 1'b1);
      if (card_valid) nv++;
    end
    n_checks++; if (nv !== 0) begin n_errors++; $display("FAIL glitch_quiet valid_cycles got %0d want 0", nv); end
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      step(7'b1111011, 1'b1);
      if (card_valid) begin nv++; c = card_code; v = card_value; end
    end
    n_checks++; if (nv !== 1) begin n_errors++; $display("FAIL glitch_settle count got %0d want 1", nv); end
    n_checks++; if (c !== 4'd9) begin n_errors++; $display("FAIL glitch_code got %0d want 9", c); end
    n_checks++; if (v !== 4'd9) begin n_errors++; $display("FAIL glitch_value got %0d want 9", v); end
  endtask

  task automatic test_error();
    repeat (8) step(7'b1000001, 1'b0);
    n_checks++; if (card_valid !== 1'b1) begin n_errors++; $display("FAIL err_valid got %b want 1", card_valid); end
    n_checks++; if (card_err !== 1'b1) begin n_errors++; $display("FAIL err_flag got %b want 1", card_err); end
    n_checks++; if (card_code !== 4'd15) begin n_errors++; $display("FAIL err_code got %0d want 15", card_code); end
    n_checks++; if (card_value !== 4'd0) begin n_errors++; $display("FAIL err_value got %0d want 0", card_value); end
    step(7'b1000001, 1'b1);
    n_checks++; if (card_valid !== 1'b0 || card_err !== 1'b0) begin n_errors++; $display("FAIL err_accept valid/err got %b/%b want 0/0", card_valid, card_err); end
  endtask

  task automatic test_hold_update();
    int k;
    k = 0;
    while (!card_valid && k < 20) begin
      step(7'b1011011, 1'b0);
      k++;
    end
    n_checks++; if (card_valid !== 1'b1 || card_code !== 4'd5) begin n_errors++; $display("FAIL hold_five valid/code got %b/%0d want 1/5", card_valid, card_code); end
    repeat (6) step(7'b1011111, 1'b0);
    n_checks++; if (card_code !== 4'd5 || card_value !== 4'd5) begin n_errors++; $display("FAIL hold_frozen code/value got %0d/%0d want 5/5", card_code, card_value); end
    step(7'b1011111, 1'b1);
    n_checks++; if (card_valid !== 1'b0) begin n_errors++; $display("FAIL hold_accept valid got %b want 0", card_valid); end
    step(7'b1011111, 1'b0);
    n_checks++; if (card_valid !== 1'b1 || card_code !== 4'd6 || card_value !== 4'd6) begin n_errors++; $display("FAIL hold_six valid/code/value got %b/%0d/%0d want 1/6/6", card_valid, card_code, card_value); end
    step(7'b1011111, 1'b1);
  endtask

  task automatic test_async_reset();
    int k;
    k = 0;
    while (!card_valid && k < 20) begin
      step(7'b1111111, 1'b0);
      k++;
    end
    n_checks++; if (card_valid !== 1'b1 || card_code !== 4'd8) begin n_errors++; $display("FAIL areset_pre valid/code got %b/%0d want 1/8", card_valid, card_code); end
    #1 resetb = 1'b0;
    #1;
    n_checks++; if (card_valid !== 1'b0 || card_code !== 4'd0 || card_value !== 4'd0 || card_err !== 1'b0) begin
      n_errors++; $display("FAIL areset_outputs valid/code/value/err got %b/%0d/%0d/%b want 0/0/0/0", card_valid, card_code, card_value, card_err);
    end
    #1 resetb = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    logic [6:0] p;
    logic rdy;
    int r, len;
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 16);
      if (r < 14) p = tbl[r];
      else p = 7'($urandom_range(0, 127));
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        rdy = ($urandom_range(0, 2) != 0);
        step(p, rdy);
        n_checks++;
        if (card_valid !== m_valid) begin
          n_errors++; $display("FAIL rand_valid got %b want %b", card_valid, m_valid);
        end else if (m_valid && (card_code !== m_code || card_value !== m_value || card_err !== m_err)) begin
          n_errors++; $display("FAIL rand_data code/value/err got %0d/%0d/%b want %0d/%0d/%b",
                               card_code, card_value, card_err, m_code, m_value, m_err);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    resetb = 1'b0;
    seg_in = 7'b0000000;
    card_ready = 1'b0;
    test_reset();
    test_blank_idle();
    test_ace();
    test_king_backpressure();
    test_glitch();
    test_error();
    test_hold_update();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_card_decode.md
Name: seg7_card_decode

Overview:
- Reverse path of the card-to-7-segment encoder: samples a 7-segment pattern, waits until it is stable, and decodes it back to the 4-bit card code plus its baccarat point value.
- Sits between a scanned or looped-back HEX display bus and the scoring/self-check logic.
- Results are delivered over a valid/ready handshake.
- Unrecognized patterns are flagged as errors rather than silently dropped.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical samples required before a pattern is reported; legal range 1..255.

Ports:
- slow_clock  input  1  single clock; all logic on its rising edge
- resetb  input  1  asynchronous, active-low reset
- seg_in  input  7  segment pattern; bit6=a … bit0=g; 1 = segment lit
- card_ready  input  1  consumer accepts the current result
- card_valid  output  1  result pending; held until accepted
- card_code  output  4  decoded card: 0 blank, 1 ace … 13 king, 15 on error
- card_value  output  4  baccarat points: code 1..9 → code; codes 0, 10..13, 15 → 0
- card_err  output  1  qualifies card_valid; pattern matched no table entry

Behaviour:
- Reset values: card_valid=0, card_err=0, card_code=0, card_value=0. Internal seg_q=0, cnt=0, last_rep=0 (blank). Reset is asynchronous and may assert mid-handshake; the pending result is discarded.
- Input stage: seg_q <= seg_in every cycle (one register; no synchroniser required).
- Stability counter, cnt, width clog2(STABLE_CYCLES+1):
  - If seg_in == seg_q, cnt increments, saturating at STABLE_CYCLES.
  - Otherwise cnt <= 1.
- Pattern is stable when cnt == STABLE_CYCLES.
- Decode table (1 = lit):
  - 0 blank 0000000
  - 1 1110111
  - 2 1101101
  - 3 1111001
  - 4 0110011
  - 5 1011011
  - 6 1011111
  - 7 1110000
  - 8 1111111
  - 9 1111011
  - 10 1111110
  - 11 0111100
  - 12 1110011
  - 13 0110111
  - Any other pattern → code 15, err=1.
- FSM:
  - TRACK:
    - When stable and seg_q != last_rep, load card_code, card_value and card_err from the decode of seg_q, set last_rep <= seg_q, assert card_valid, go to HOLD.
    - A stable pattern equal to last_rep is never re-reported.
  - HOLD:
    - Outputs are frozen.
    - When card_valid && card_ready, deassert card_valid and card_err, go to TRACK.
    - Stability tracking continues during HOLD.
    - If a new pattern became stable during HOLD, it is reported in the first TRACK cycle, so card_valid rises again one cycle after the accept.
    - Only the latest stable pattern is reported; intermediate ones are lost by design.
- Latency: seg_in first presented before edge k and held → card_valid high after edge k+STABLE_CYCLES (STABLE_CYCLES=4: valid visible after the 4th edge from k).
- Handshake:
  - card_valid never drops without acceptance.
  - card_code, card_value and card_err are stable while valid.
  - card_ready while not valid is ignored.
- Blank after reset is not reported, because last_rep starts as blank.
- A return to blank after a card is a change and is reported as code 0.
- Changing seg_in while cnt < STABLE_CYCLES restarts the count; glitches shorter than STABLE_CYCLES cycles never produce output.

Optional Feature:
- SEG_ACTIVE_LOW_EN:
  - Defined: seg_in is the raw active-low DE-board HEX drive and is inverted at the input stage, before seg_q.
  - Undefined: seg_in is active-high as above.
- All other behaviour is identical, including comparisons and last_rep, which use the internal active-high form.

Decomposition:
- Package card_pkg holds:
  - the 4-bit card code constants (CARD_BLANK, CARD_ACE … CARD_KING, CARD_ERR=15);
  - the 7-bit segment pattern constants shared with the encoder;
  - the FSM state enum {TRACK, HOLD}.
- One sub-module is natural: seg_stable_filter. It contains the input register, the saturating counter and the stable flag, parameterized by STABLE_CYCLES. The top level holds decode, last_rep and the FSM.

Test Plan:
- Reset, then seg_in=0 for 20 cycles, card_ready=1 → card_valid stays 0.
- seg_in=1110111 held with STABLE_CYCLES=4, card_ready=1 → one valid cycle; card_code=1, card_value=1, card_err=0; no repeat while the pattern is held.
- seg_in=0110111 (king), card_ready=0 for 10 cycles, then 1 → valid held with code 13, value 0 until accept; drops the cycle after accept.
- seg_in toggles between 1111111 and 1111011 every 2 cycles for 30 cycles, then settles on 1111011 → no output during toggling; single report, code 9, value 9.
- seg_in=1000001 held → card_valid=1, card_err=1, card_code=15, card_value=0.
- Code 5 pending in HOLD while seg_in moves to 1011111 and stabilises; accept → code 6 valid one cycle later. Separately, assert resetb=0 mid-HOLD → all outputs 0 asynchronously.
